dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 14 +
 rtl/dmem_arbiter_if.sv | 27 ++
 rtl/dmem_arb_grant.sv | 18 +
 rtl/dmem_arbiter.sv | 139 +++++++++++++
 tb/tb_dmem_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the two-port data-memory arbiter: FSM encoding and default sizes.
package dmem_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_DEPTH  = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// One client port of the data-memory arbiter: request channel plus response channel.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = dmem_arbiter_pkg::DEF_ADDR_W,
  parameter int unsigned DATA_W = dmem_arbiter_pkg::DEF_DATA_W
) ();

  logic              req_valid;
  logic              req_ready;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, we, addr, wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, we, addr, wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_arb_grant.sv
// Two-way winner selection: a lone requester always wins; on a tie the port not granted last wins.
module dmem_arb_grant (
  input  logic [1:0] i_valid,
  input  logic       i_last_grant,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    case (i_valid)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = i_last_grant ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a 1-cycle synchronous-read data memory, one transaction in flight.
// Build option: DMEM_ARB_ROUND_ROBIN_EN enables tie fairness; otherwise port 0 always wins ties.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  dmem_arbiter_if.slave     p0,
  dmem_arbiter_if.slave     p1,
  output logic              mem_wEn,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy
);

  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  arb_state_e        r_state;
  arb_state_e        w_next_state;
  logic              r_port;
  logic              r_we;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic [1:0]        w_valid;
  logic [1:0]        w_grant;
  logic              w_last_grant;
  logic              w_take;
  logic [ADDR_W-1:0] w_req_addr;
  logic              w_in_range;
  logic              w_rsp_ready;
  logic [DATA_W-1:0] w_rsp_data;

  assign w_valid     = {p1.req_valid, p0.req_valid};
  assign w_take      = (r_state == ST_IDLE) && (w_valid != 2'b00);
  assign w_req_addr  = w_grant[1] ? p1.addr : p0.addr;
  assign w_in_range  = ({1'b0, w_req_addr} < DEPTH_X);
  assign w_rsp_ready = r_port ? p1.rsp_ready : p0.rsp_ready;
  // Stores echo the written value; out-of-range accesses return zero.
  assign w_rsp_data  = r_err ? '0 : (r_we ? r_wdata : mem_read_data);

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic r_last_grant;

  always_ff @(posedge clk) begin
    if (rst)         r_last_grant <= 1'b1;
    else if (w_take) r_last_grant <= w_grant[1];
  end

  assign w_last_grant = r_last_grant;
`else
  assign w_last_grant = 1'b1;
`endif

  dmem_arb_grant u_grant (
    .i_valid      (w_valid),
    .i_last_grant (w_last_grant),
    .o_grant      (w_grant)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Request latch captured on the grant cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_port  <= 1'b0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_take) begin
      r_port  <= w_grant[1];
      r_we    <= w_grant[1] ? p1.we : p0.we;
      r_addr  <= w_req_addr;
      r_wdata <= w_grant[1] ? p1.wdata : p0.wdata;
      r_err   <= !w_in_range;
    end
  end

  // Next state and outputs; everything is forced low while rst is asserted.
  always_comb begin
    w_next_state   = r_state;
    p0.req_ready   = 1'b0;
    p1.req_ready   = 1'b0;
    p0.rsp_valid   = 1'b0;
    p1.rsp_valid   = 1'b0;
    p0.rsp_rdata   = '0;
    p1.rsp_rdata   = '0;
    p0.rsp_err     = 1'b0;
    p1.rsp_err     = 1'b0;
    mem_wEn        = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    busy           = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_valid != 2'b00) w_next_state = ST_ACCESS;
        p0.req_ready = w_grant[0] && !rst;
        p1.req_ready = w_grant[1] && !rst;
      end
      ST_ACCESS: begin
        w_next_state   = ST_RESP;
        busy           = !rst;
        mem_address    = rst ? '0 : r_addr;
        mem_write_data = rst ? '0 : r_wdata;
        mem_wEn        = r_we && !r_err && !rst;
      end
      ST_RESP: begin
        if (w_rsp_ready) w_next_state = ST_IDLE;
        busy           = !rst;
        mem_address    = rst ? '0 : r_addr;
        mem_write_data = rst ? '0 : r_wdata;
        if (!rst) begin
          if (r_port) begin
            p1.rsp_valid = 1'b1;
            p1.rsp_rdata = w_rsp_data;
            p1.rsp_err   = r_err;
          end else begin
            p0.rsp_valid = 1'b1;
            p0.rsp_rdata = w_rsp_data;
            p0.rsp_err   = r_err;
          end
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: per-cycle transaction-level model plus directed literal checks.
module tb_dmem_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned DEPTH = 16;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_wEn;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write_data;
  logic [DW-1:0] mem_read_data;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) if0 ();
  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) if1 ();

  dmem_arbiter #(.ADDR_W(AW), .DEPTH(DEPTH), .DATA_W(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .p0             (if0),
    .p1             (if1),
    .mem_wEn        (mem_wEn),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Harness memory: synchronous read, one-cycle latency.
  logic [DW-1:0] hmem [DEPTH];
  initial begin
    for (int i = 0; i < int'(DEPTH); i++) hmem[i] = '0;
    mem_read_data = '0;
  end
  always @(posedge clk) begin
    if (mem_wEn && mem_address < AW'(DEPTH)) hmem[mem_address[3:0]] <= mem_write_data;
    mem_read_data <= (mem_address < AW'(DEPTH)) ? hmem[mem_address[3:0]] : '0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pick(logic v0, logic v1, logic last);
    if (v0 && !v1) return 0;
    if (v1 && !v0) return 1;
    return (RR && !last) ? 1 : 0;
  endfunction

  // Reference model: at most one transaction; phase 1 = memory access cycle, phase 2 = response.
  logic [DW-1:0] ref_mem [DEPTH];
  bit            m_inflight = 0;
  int            m_phase = 0;
  bit            m_last = 1;
  int            m_port;
  bit            m_we;
  bit            m_err;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_data;

  initial for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;

  always @(negedge clk) begin : model
    logic          e_busy, e_wen, e_wd_chk;
    logic [1:0]    e_rdy, e_rv, e_re;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd, e_rd0, e_rd1;
    int            w;
    e_busy = 0; e_wen = 0; e_wd_chk = 1; e_rdy = 0; e_rv = 0; e_re = 0;
    e_addr = '0; e_wd = '0; e_rd0 = '0; e_rd1 = '0;
    if (rst) begin
      m_inflight = 0;
      m_phase = 0;
      m_last = 1;
    end else if (!m_inflight) begin
      if (if0.req_valid || if1.req_valid) begin
        w = pick(if0.req_valid, if1.req_valid, m_last);
        e_rdy[w] = 1'b1;
        m_port  = w;
        m_we    = (w == 1) ? if1.we : if0.we;
        m_addr  = (w == 1) ? if1.addr : if0.addr;
        m_wdata = (w == 1) ? if1.wdata : if0.wdata;
        m_err   = (m_addr >= AW'(DEPTH));
        m_data  = m_err ? '0 : (m_we ? m_wdata : ref_mem[m_addr[3:0]]);
        m_last  = (w == 1);
        m_inflight = 1;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      e_busy = 1;
      e_addr = m_addr;
      e_wd   = m_wdata;
      e_wen  = m_we && !m_err;
      if (e_wen) ref_mem[m_addr[3:0]] = m_wdata;
      m_phase = 2;
    end else begin
      e_busy = 1;
      e_addr = m_addr;
      e_wd_chk = 0;
      e_rv[m_port] = 1'b1;
      e_re[m_port] = m_err;
      if (m_port == 0) e_rd0 = m_data;
      else             e_rd1 = m_data;
      if ((m_port == 0) ? if0.rsp_ready : if1.rsp_ready) m_inflight = 0;
    end
    chk("busy", 32'(busy), 32'(e_busy));
    chk("mem_wEn", 32'(mem_wEn), 32'(e_wen));
    chk("mem_address", 32'(mem_address), 32'(e_addr));
    if (e_wd_chk) chk("mem_write_data", mem_write_data, e_wd);
    chk("p0_req_ready", 32'(if0.req_ready), 32'(e_rdy[0]));
    chk("p1_req_ready", 32'(if1.req_ready), 32'(e_rdy[1]));
    chk("p0_rsp_valid", 32'(if0.rsp_valid), 32'(e_rv[0]));
    chk("p1_rsp_valid", 32'(if1.rsp_valid), 32'(e_rv[1]));
    chk("p0_rsp_err", 32'(if0.rsp_err), 32'(e_re[0]));
    chk("p1_rsp_err", 32'(if1.rsp_err), 32'(e_re[1]));
    chk("p0_rsp_rdata", if0.rsp_rdata, e_rd0);
    chk("p1_rsp_rdata", if1.rsp_rdata, e_rd1);
  end

  function automatic logic rsp_v(int p);
    return (p == 0) ? if0.rsp_valid : if1.rsp_valid;
  endfunction
  function automatic logic [DW-1:0] rsp_d(int p);
    return (p == 0) ? if0.rsp_rdata : if1.rsp_rdata;
  endfunction
  function automatic logic rsp_e(int p);
    return (p == 0) ? if0.rsp_err : if1.rsp_err;
  endfunction

  // Present a request and wait (bounded) for its handshake; returns at posedge+1 after it.
  task automatic issue(input int port, input bit we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, output bit ok);
    if (port == 0) begin
      if0.we = we; if0.addr = addr; if0.wdata = wdata; if0.req_valid = 1'b1;
    end else begin
      if1.we = we; if1.addr = addr; if1.wdata = wdata; if1.req_valid = 1'b1;
    end
    ok = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if ((port == 0) ? if0.req_ready : if1.req_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL handshake_timeout: port %0d got no req_ready, expected within 20 cycles", port);
    end
    @(posedge clk); #1;
    if (port == 0) if0.req_valid = 1'b0;
    else           if1.req_valid = 1'b0;
  endtask

  // Full transaction with literal expectations at T+1 (access) and T+2 (response).
  task automatic txn(input string name, input int port, input bit we, input logic [AW-1:0] addr,
                     input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rd,
                     input bit exp_err, input bit exp_wen);
    bit ok;
    issue(port, we, addr, wdata, ok);
    if (!ok) return;
    @(negedge clk);
    chk({name, "_t1_wen"}, 32'(mem_wEn), 32'(exp_wen));
    chk({name, "_t1_rspv"}, 32'(rsp_v(port)), 32'd0);
    @(negedge clk);
    chk({name, "_t2_rspv"}, 32'(rsp_v(port)), 32'd1);
    chk({name, "_t2_rdata"}, rsp_d(port), exp_rd);
    chk({name, "_t2_err"}, 32'(rsp_e(port)), 32'(exp_err));
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  int grants[$];
  int exp_g[4];
  bit ok;
  logic [DW-1:0] held;

  initial begin
    rst = 1'b1;
    if0.req_valid = 0; if0.we = 0; if0.addr = '0; if0.wdata = '0; if0.rsp_ready = 1;
    if1.req_valid = 0; if1.we = 0; if1.addr = '0; if1.wdata = '0; if1.rsp_ready = 1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_wEn", 32'(mem_wEn), 32'd0);
    chk("rst_p0_rspv", 32'(if0.rsp_valid), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Store then load on port 0.
    txn("st3", 0, 1'b1, AW'(3), 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b1);
    txn("ld3", 0, 1'b0, AW'(3), 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);

    // Both ports requesting continuously from reset.
    do_reset(2);
    if0.we = 0; if0.addr = AW'(2); if0.req_valid = 1;
    if1.we = 0; if1.addr = AW'(4); if1.req_valid = 1;
    for (int n = 0; n < 40 && grants.size() < 4; n++) begin
      @(negedge clk);
      if (if0.req_ready) grants.push_back(0);
      if (if1.req_ready) grants.push_back(1);
    end
    @(posedge clk); #1;
    if0.req_valid = 0; if1.req_valid = 0;
    repeat (5) begin @(posedge clk); #1; end
    exp_g = RR ? '{0, 1, 0, 1} : '{0, 0, 0, 0};
    chk("tie_grant_count", 32'(grants.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < grants.size()) chk($sformatf("tie_grant_%0d", i), 32'(grants[i]), 32'(exp_g[i]));

    // Out-of-range accesses on port 1.
    txn("oor_ld20", 1, 1'b0, AW'(20), 32'h0, 32'h0, 1'b1, 1'b0);
    txn("oor_st16", 1, 1'b1, AW'(16), 32'h5555AAAA, 32'h0, 1'b1, 1'b0);
    txn("ld0_clean", 0, 1'b0, AW'(0), 32'h0, 32'h0, 1'b0, 1'b0);

    // Response back-pressure on port 0 while port 1 waits.
    txn("st7", 0, 1'b1, AW'(7), 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 1'b1);
    if0.rsp_ready = 0;
    issue(0, 1'b0, AW'(7), 32'h0, ok);
    if1.we = 0; if1.addr = AW'(1); if1.req_valid = 1;
    @(negedge clk);
    chk("stall_t1_p1_rdy", 32'(if1.req_ready), 32'd0);
    @(negedge clk);
    held = if0.rsp_rdata;
    chk("stall_first_rdata", held, 32'hCAFEF00D);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("stall_rspv_%0d", k), 32'(if0.rsp_valid), 32'd1);
      chk($sformatf("stall_rdata_%0d", k), if0.rsp_rdata, held);
      chk($sformatf("stall_p1_rdy_%0d", k), 32'(if1.req_ready), 32'd0);
      chk($sformatf("stall_busy_%0d", k), 32'(busy), 32'd1);
    end
    @(posedge clk); #1 if0.rsp_ready = 1;
    ok = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (if1.req_ready) begin ok = 1; break; end
    end
    chk("stall_p1_granted", 32'(ok), 32'd1);
    @(posedge clk); #1 if1.req_valid = 0;
    repeat (4) begin @(posedge clk); #1; end

    // Reset during the access cycle of a store.
    issue(0, 1'b1, AW'(5), 32'h12345678, ok);
    rst = 1'b1;
    @(negedge clk);
    chk("rstacc_wen", 32'(mem_wEn), 32'd0);
    chk("rstacc_rspv", 32'(if0.rsp_valid), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rstacc_norsp_%0d", k), 32'(if0.rsp_valid), 32'd0);
    end
    @(posedge clk); #1;
    txn("rstacc_ld5", 0, 1'b0, AW'(5), 32'h0, 32'h0, 1'b0, 1'b0);

    // Randomized traffic, occasional reset; the model checks every cycle.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 149) == 0);
      if0.req_valid = ($urandom_range(0, 2) == 0);
      if0.we        = 1'($urandom_range(0, 1));
      if0.addr      = AW'($urandom_range(0, 19));
      if0.wdata     = $urandom;
      if0.rsp_ready = ($urandom_range(0, 3) != 0);
      if1.req_valid = ($urandom_range(0, 2) == 0);
      if1.we        = 1'($urandom_range(0, 1));
      if1.addr      = AW'($urandom_range(0, 19));
      if1.wdata     = $urandom;
      if1.rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    rst = 0;
    if0.req_valid = 0; if1.req_valid = 0; if0.rsp_ready = 1; if1.rsp_ready = 1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
